// File: rtl/blink_seq_ctrl.sv
// blink_seq_ctrl
//   Sequences an LED bank from a slow tick. On an accepted start the config
//   (on_len, off_len, rep_num, pattern) is latched. The LEDs then show the
//   pattern for max(on_len,1) ticks and are dark for max(off_len,1) ticks.
//   This repeats rep_num times, or until stop when rep_num is 0.
//
//   Optional feature macro: BLINK_SEQ_ROTATE_EN
//     Defined:   each OFF->ON transition rotates the latched pattern left by 1
//                (MSB wraps to bit 0). The first ON phase shows it as latched.
//     Undefined: the latched pattern is shown unchanged on every ON phase.
//
// Ports
//   CLK      in   1      system clock
//   RST      in   1      synchronous, active-high reset
//   tick     in   1      1-cycle enable pulse (1 Hz)
//   start    in   1      latch config and begin; honoured in IDLE only
//   stop     in   1      abort to IDLE from any state; beats start and tick
//   on_len   in   CNT_W  ticks lit per blink cycle (0 treated as 1)
//   off_len  in   CNT_W  ticks dark per blink cycle (0 treated as 1)
//   rep_num  in   REP_W  blink cycles to run (0 = until stop)
//   pattern  in   LED_W  LED value shown during ON
//   led      out  LED_W  registered LED drive
//   busy     out  1      high while in ON/OFF
//   done     out  1      1-cycle pulse on normal completion

module blink_seq_ctrl #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned LED_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] on_len,
  input  logic [CNT_W-1:0] off_len,
  input  logic [REP_W-1:0] rep_num,
  input  logic [LED_W-1:0] pattern,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] on_len_q;
  logic [CNT_W-1:0] off_len_q;
  logic [REP_W-1:0] rep_num_q;
  logic [LED_W-1:0] pat_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [REP_W-1:0] rep_cnt_q;

  // Terminal tick counts; a zero length behaves as one tick.
  logic [CNT_W-1:0] on_last;
  logic [CNT_W-1:0] off_last;
  logic             rep_last;
  logic [LED_W-1:0] next_pat;

  assign on_last  = (on_len_q == '0)  ? '0 : on_len_q - 1'b1;
  assign off_last = (off_len_q == '0) ? '0 : off_len_q - 1'b1;
  assign rep_last = (rep_num_q != '0) && (rep_cnt_q == rep_num_q - 1'b1);

`ifdef BLINK_SEQ_ROTATE_EN
  assign next_pat = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
`else
  assign next_pat = pat_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tick_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state_q    <= StIdle;
        led        <= '0;
        busy       <= 1'b0;
        tick_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              on_len_q   <= on_len;
              off_len_q  <= off_len;
              rep_num_q  <= rep_num;
              pat_q      <= pattern;
              state_q    <= StOn;
              led        <= pattern;
              busy       <= 1'b1;
              tick_cnt_q <= '0;
              rep_cnt_q  <= '0;
            end
          end
          StOn: begin
            if (tick) begin
              if (tick_cnt_q == on_last) begin
                state_q    <= StOff;
                led        <= '0;
                tick_cnt_q <= '0;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
          StOff: begin
            if (tick) begin
              if (tick_cnt_q == off_last) begin
                tick_cnt_q <= '0;
                if (rep_last) begin
                  state_q   <= StIdle;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  rep_cnt_q <= '0;
                end else begin
                  state_q <= StOn;
                  led     <= next_pat;
                  pat_q   <= next_pat;
                  // Unbounded runs keep the repeat counter parked.
                  if (rep_num_q != '0) begin
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                  end
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q    <= StIdle;
            led        <= '0;
            busy       <= 1'b0;
            tick_cnt_q <= '0;
            rep_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

endmodule
